wb_stream_master: RTL



---
 rtl/wb_stream_master.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_stream_master.sv
// rtl/wb_stream_master.sv - byte-stream command parser driving a pipelined Wishbone master
module wb_stream_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [3:0]  SEL_ALL        = 4'hF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_stall_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_WR      = 8'h01;
  localparam logic [7:0] OP_RD      = 8'h02;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BUSERR  = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_BADOP   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic          is_write_q, is_write_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    rem_q, rem_d;
  logic          rx_ready_q, rx_ready_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;

  logic rx_fire;
  logic tx_fire;
  logic opcode_ok;
  logic tmo_hit;
  logic bus_done;
  logic start_bus;

  assign rx_fire   = rx_valid_i & rx_ready_q;
  assign tx_fire   = tx_valid_q & tx_ready_i;
  assign opcode_ok = (rx_data_i == OP_WR) || (rx_data_i == OP_RD);
  // The counter is compared one short so cyc is already low on the cycle it would reach the limit.
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign bus_done  = (state_q == S_BUS) && (wbm_ack_i || wbm_err_i || tmo_hit);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_fire) state_d = opcode_ok ? S_ADDR : S_RESP;
      S_ADDR:  if (rx_fire && bcnt_q == 2'd3) state_d = is_write_q ? S_WDATA : S_BUS;
      S_WDATA: if (rx_fire && bcnt_q == 2'd3) state_d = S_BUS;
      S_BUS:   if (bus_done) state_d = S_RESP;
      S_RESP:  if (tx_fire && rem_q == 3'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    is_write_d = is_write_q;
    bcnt_d     = bcnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    tmo_d      = tmo_q;
    rdata_d    = rdata_q;
    rem_d      = rem_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    start_bus  = 1'b0;
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          is_write_d = (rx_data_i == OP_WR);
          bcnt_d     = 2'd0;
          wdata_d    = 32'h0;
          if (!opcode_ok) begin
            rem_d      = 3'd0;
            tx_data_d  = ST_BADOP;
            tx_valid_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          addr_d = {rx_data_i, addr_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3 && !is_write_q) start_bus = 1'b1;
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          wdata_d = {rx_data_i, wdata_q[31:8]};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) start_bus = 1'b1;
        end
      end
      S_BUS: begin
        tmo_d = tmo_q + TW'(1);
        if (stb_q && !wbm_stall_i) stb_d = 1'b0;
        if (bus_done) begin
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          we_d       = 1'b0;
          sel_d      = 4'h0;
          tmo_d      = '0;
          tx_valid_d = 1'b1;
          rem_d      = 3'd0;
          if (wbm_err_i) begin
            tx_data_d = ST_BUSERR;
          end else if (wbm_ack_i) begin
            tx_data_d = ST_OK;
            if (!is_write_q) begin
              rdata_d = wbm_dat_i;
              rem_d   = 3'd4;
            end
          end else begin
            tx_data_d = ST_TIMEOUT;
          end
        end
      end
      S_RESP: begin
        if (tx_fire) begin
          if (rem_q == 3'd0) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
          end else begin
            tx_data_d = rdata_q[7:0];
            rdata_d   = {8'h00, rdata_q[31:8]};
            rem_d     = rem_q - 3'd1;
          end
        end
      end
      default: ;
    endcase

    if (start_bus) begin
      cyc_d = 1'b1;
      stb_d = 1'b1;
      we_d  = is_write_q;
      sel_d = SEL_ALL;
      adr_d = addr_d;
      dat_d = wdata_d;
      tmo_d = '0;
    end
  end

  // Datapath registers, all cleared by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      is_write_q <= 1'b0;
      bcnt_q     <= 2'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      adr_q      <= 32'h0;
      dat_q      <= 32'h0;
      sel_q      <= 4'h0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      tmo_q      <= '0;
      rdata_q    <= 32'h0;
      rem_q      <= 3'd0;
      rx_ready_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      is_write_q <= is_write_d;
      bcnt_q     <= bcnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      tmo_q      <= tmo_d;
      rdata_q    <= rdata_d;
      rem_q      <= rem_d;
      rx_ready_q <= rx_ready_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;
  assign wbm_sel_o  = sel_q;
  assign wbm_we_o   = we_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = stb_q;
  assign rx_ready_o = rx_ready_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;

endmodule
